// File: rtl/fifo_rd_burst_ctrl.sv
// rtl/fifo_rd_burst_ctrl.sv - burst read sequencer for the read port of a dual-clock FIFO
// Optional partial-burst flush after an idle timeout: define FIFO_RD_TIMEOUT_EN.
module fifo_rd_burst_ctrl #(
    parameter int DATA_W      = 16,
    parameter int USEDW_W     = 8,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_RD_LAT = 1,
    parameter int OBUF_DEPTH  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_rd_empty,
    input  logic [USEDW_W-1:0] fifo_rd_usedw,
    output logic               fifo_rd_req,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               burst_done
);
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_RD_LAT < 1 || FIFO_RD_LAT > 2 || OBUF_DEPTH < FIFO_RD_LAT + 2 || BURST_LEN < 1
        || BURST_LEN >= (1 << USEDW_W) || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_rd_burst_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    state_t state, state_nxt;

    logic [USEDW_W-1:0]     remaining;
    logic [USEDW_W-1:0]     burst_len;
    logic                   start;
    logic [FIFO_RD_LAT-1:0] req_pipe;
    logic [FIFO_RD_LAT-1:0] last_pipe;
    logic                   capture;
    logic                   pop;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W:0]         credit_used;

    logic [DATA_W-1:0]      buf_data [OBUF_DEPTH];
    logic [OBUF_DEPTH-1:0]  buf_last;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       buf_count;

    assign capture     = req_pipe[FIFO_RD_LAT-1];
    assign m_valid     = (buf_count != '0);
    assign pop         = m_valid && m_ready;
    assign m_data      = m_valid ? buf_data[rd_ptr] : '0;
    assign m_last      = m_valid && buf_last[rd_ptr];
    assign busy        = (state != IDLE);
    assign credit_used = {1'b0, buf_count} + {1'b0, inflight};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FIFO_RD_LAT; i++) begin
            inflight = inflight + CNT_W'(req_pipe[i]);
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_cond;
    logic             tmo_hit;

    // Residual words below the threshold are flushed once they sit idle for TIMEOUT cycles.
    assign tmo_cond = (state == IDLE) && en && (fifo_rd_usedw != '0)
                      && (fifo_rd_usedw < USEDW_W'(BURST_LEN));
    assign tmo_hit  = tmo_cond && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !tmo_cond || start) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        fifo_rd_req = 1'b0;
        start       = 1'b0;
        burst_len   = USEDW_W'(BURST_LEN);
        burst_done  = 1'b0;
        case (state)
            IDLE: begin
                if (en && (fifo_rd_usedw >= USEDW_W'(BURST_LEN))) begin
                    start     = 1'b1;
                    state_nxt = BURST;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (tmo_hit) begin
                    start     = 1'b1;
                    burst_len = fifo_rd_usedw;
                    state_nxt = BURST;
                end
`endif
            end
            BURST: begin
                // Only request when a buffer slot is guaranteed for the returning word.
                fifo_rd_req = (remaining != '0) && !fifo_rd_empty
                              && (credit_used < (CNT_W + 1)'(OBUF_DEPTH));
                if (fifo_rd_req && (remaining == USEDW_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    burst_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            req_pipe  <= '0;
            last_pipe <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                remaining <= burst_len;
            end else if (fifo_rd_req) begin
                remaining <= remaining - USEDW_W'(1);
            end
            req_pipe[0]  <= fifo_rd_req;
            last_pipe[0] <= fifo_rd_req && (remaining == USEDW_W'(1));
            for (int i = 1; i < FIFO_RD_LAT; i++) begin
                req_pipe[i]  <= req_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (capture && !pop) begin
                buf_count <= buf_count + CNT_W'(1);
            end else if (!capture && pop) begin
                buf_count <= buf_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (capture) begin
            buf_data[wr_ptr] <= fifo_rd_data;
            buf_last[wr_ptr] <= last_pipe[FIFO_RD_LAT-1];
        end
    end

    a_obuf_bound: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                                   buf_count <= CNT_W'(OBUF_DEPTH));

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// tb/tb_fifo_rd_burst_ctrl.sv - self-checking bench for fifo_rd_burst_ctrl
// FIFO_RD_TIMEOUT_EN selects the partial-burst scenario instead of the below-threshold one.
module tb_fifo_rd_burst_ctrl;
    localparam int BURST_LEN   = 16;
    localparam int FIFO_RD_LAT = 1;
    localparam int TIMEOUT     = 255;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] fifo_rd_data = '0;
    logic        fifo_rd_empty = 1'b1;
    logic [7:0]  fifo_rd_usedw = '0;
    logic        fifo_rd_req;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        burst_done;

    always #5 clk = ~clk;

    fifo_rd_burst_ctrl #(
        .DATA_W(16), .USEDW_W(8), .BURST_LEN(BURST_LEN), .FIFO_RD_LAT(FIFO_RD_LAT),
        .OBUF_DEPTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .en(en),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_usedw(fifo_rd_usedw),
        .fifo_rd_req(fifo_rd_req), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .burst_done(burst_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural FIFO: one write per cycle, read data valid one cycle after rdreq.
    logic [15:0] fifo_q[$];
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    int          extra_words = 0;

    always @(posedge clk) begin
        if (fifo_rd_req && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_rd_empty <= (fifo_q.size() == 0);
        fifo_rd_usedw <= 8'(fifo_q.size() + extra_words);
    end

    int rdy_mode = 0;
    int phase = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (phase % 4 == 0) || (phase % 4 == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        phase = phase + 1;
    end

    // Recorder of stream beats and protocol events; tasks compare against it.
    logic [15:0] got_data[$];
    logic        got_last[$];
    int          run_hist[$];
    int          bad_req = 0, unstable = 0, done_cnt = 0, req_total = 0, cur_run = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
        end
        if (fifo_rd_req && fifo_rd_empty) bad_req++;
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) unstable++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (burst_done) done_cnt++;
        if (fifo_rd_req) begin
            req_total++;
            cur_run++;
        end else if (cur_run != 0) begin
            run_hist.push_back(cur_run);
            cur_run = 0;
        end
    end

    logic [15:0] exp_q[$];

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_data = 16'($urandom);
            wr_en   = 1'b1;
            exp_q.push_back(wr_data);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({fifo_rd_req, m_valid, m_last, busy, burst_done} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got=%b exp=00000", {fifo_rd_req, m_valid, m_last, busy, burst_done});
        end
        n_checks++;
        if (m_data !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_m_data got=%h exp=0000", m_data);
        end
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic test_full_burst();
        int base, rbase, dbase, busy_c, valid_c;
        rdy_mode = 0; en = 1'b0; exp_q.delete();
        write_words(16);
        base = got_data.size(); rbase = run_hist.size(); dbase = done_cnt;
        en = 1'b1; busy_c = -1; valid_c = -1;
        for (int c = 1; c <= 300 && got_data.size() < base + 16; c++) begin
            @(negedge clk); #1;
            if (busy_c < 0 && busy) busy_c = c;
            if (valid_c < 0 && m_valid) valid_c = c;
        end
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (got_data.size() != base + 16) begin
            n_errors++;
            $display("FAIL full_beats got=%0d exp=16", got_data.size() - base);
        end
        for (int i = 0; i < 16 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i == 15)) begin
                n_errors++;
                $display("FAIL full_word%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i == 15);
            end
        end
        n_checks++;
        if (valid_c - busy_c != FIFO_RD_LAT + 1) begin
            n_errors++;
            $display("FAIL full_latency got=%0d exp=%0d", valid_c - busy_c, FIFO_RD_LAT + 1);
        end
        n_checks++;
        if (run_hist.size() <= rbase || run_hist[rbase] != 16) begin
            n_errors++;
            $display("FAIL full_req_run got=%0d exp=16", run_hist.size() > rbase ? run_hist[rbase] : 0);
        end
        n_checks++;
        if (done_cnt - dbase != 1 || busy !== 1'b0 || fifo_rd_usedw !== 8'd0) begin
            n_errors++;
            $display("FAIL full_end got=done%0d/busy%b/usedw%0d exp=done1/busy0/usedw0",
                     done_cnt - dbase, busy, fifo_rd_usedw);
        end
    endtask

    task automatic test_below_threshold();
        int base, rq, dbase;
        rdy_mode = 2; en = 1'b1; exp_q.delete();
        write_words(15);
        rq = req_total;
        repeat (1000) @(negedge clk);
        #1;
        n_checks++;
        if (req_total != rq || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL below_idle got=reqs%0d/busy%b exp=reqs0/busy0", req_total - rq, busy);
        end
        base = got_data.size(); dbase = done_cnt;
        write_words(1);
        for (int c = 0; c < 600 && got_data.size() < base + 16; c++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (got_data.size() != base + 16 || done_cnt - dbase != 1) begin
            n_errors++;
            $display("FAIL below_burst got=beats%0d/done%0d exp=beats16/done1",
                     got_data.size() - base, done_cnt - dbase);
        end
        for (int i = 0; i < 16 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i == 15)) begin
                n_errors++;
                $display("FAIL below_word%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i == 15);
            end
        end
    endtask

    task automatic test_ready_stall();
        int base, dbase, ub;
        rdy_mode = 1; en = 1'b0; exp_q.delete();
        write_words(16);
        base = got_data.size(); dbase = done_cnt; ub = unstable;
        en = 1'b1;
        for (int c = 0; c < 400 && got_data.size() < base + 16; c++) begin
            @(negedge clk); #1;
        end
        repeat (4) @(negedge clk); #1;
        n_checks++;
        if (got_data.size() != base + 16 || done_cnt - dbase != 1) begin
            n_errors++;
            $display("FAIL stall_burst got=beats%0d/done%0d exp=beats16/done1",
                     got_data.size() - base, done_cnt - dbase);
        end
        for (int i = 0; i < 16 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i == 15)) begin
                n_errors++;
                $display("FAIL stall_word%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i == 15);
            end
        end
        n_checks++;
        if (unstable != ub) begin
            n_errors++;
            $display("FAIL stall_hold got=%0d exp=0", unstable - ub);
        end
    endtask

    task automatic test_empty_stall();
        int base, rbase, dbase, bb;
        rdy_mode = 0; en = 1'b0; exp_q.delete();
        extra_words = 6;
        write_words(10);
        base = got_data.size(); rbase = run_hist.size(); dbase = done_cnt; bb = bad_req;
        en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        extra_words = 0;
        write_words(6);
        for (int c = 0; c < 300 && got_data.size() < base + 16; c++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (run_hist.size() <= rbase || run_hist[rbase] != 10) begin
            n_errors++;
            $display("FAIL empty_first_run got=%0d exp=10", run_hist.size() > rbase ? run_hist[rbase] : 0);
        end
        n_checks++;
        if (bad_req != bb) begin
            n_errors++;
            $display("FAIL empty_underflow got=%0d exp=0", bad_req - bb);
        end
        n_checks++;
        if (got_data.size() != base + 16 || done_cnt - dbase != 1) begin
            n_errors++;
            $display("FAIL empty_burst got=beats%0d/done%0d exp=beats16/done1",
                     got_data.size() - base, done_cnt - dbase);
        end
        for (int i = 0; i < 16 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i == 15)) begin
                n_errors++;
                $display("FAIL empty_word%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i == 15);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int base, dbase, n;
        rdy_mode = 0; en = 1'b0; exp_q.delete();
        write_words(16);
        base = got_data.size();
        en = 1'b1;
        for (int c = 0; c < 100 && got_data.size() < base + 7; c++) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (got_data.size() < base + 7) begin
            n_errors++;
            $display("FAIL rstmid_reach7 got=%0d exp=7", got_data.size() - base);
        end
        for (int i = 0; i < 7 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rstmid_word%0d got=%h exp=%h", i, got_data[base+i], exp_q[i]);
            end
        end
        sys_rst_n = 1'b0;
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        n_checks++;
        if ({fifo_rd_req, m_valid, m_last, busy, burst_done} !== 5'b0 || m_data !== 16'h0) begin
            n_errors++;
            $display("FAIL rstmid_outputs got=%b/%h exp=00000/0000",
                     {fifo_rd_req, m_valid, m_last, busy, burst_done}, m_data);
        end
        exp_q.delete();
        foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);
        n = exp_q.size();
        base = got_data.size(); dbase = done_cnt;
        write_words(32 - n);
        for (int c = 0; c < 500 && got_data.size() < base + 32; c++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (got_data.size() != base + 32 || done_cnt - dbase != 2 || fifo_rd_usedw !== 8'd0) begin
            n_errors++;
            $display("FAIL rstmid_after got=beats%0d/done%0d/usedw%0d exp=beats32/done2/usedw0",
                     got_data.size() - base, done_cnt - dbase, fifo_rd_usedw);
        end
        for (int i = 0; i < 32 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i % 16 == 15)) begin
                n_errors++;
                $display("FAIL rstmid_word_after%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i % 16 == 15);
            end
        end
    endtask

`ifdef FIFO_RD_TIMEOUT_EN
    task automatic test_timeout();
        int base, dbase, busy_c;
        rdy_mode = 0; en = 1'b0; exp_q.delete();
        write_words(5);
        base = got_data.size(); dbase = done_cnt; busy_c = -1;
        en = 1'b1;
        for (int c = 1; c <= 400 && busy_c < 0; c++) begin
            @(negedge clk); #1;
            if (busy) busy_c = c;
        end
        n_checks++;
        if (busy_c != TIMEOUT) begin
            n_errors++;
            $display("FAIL tmo_start got=%0d exp=%0d", busy_c, TIMEOUT);
        end
        for (int c = 0; c < 100 && got_data.size() < base + 5; c++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (got_data.size() != base + 5 || done_cnt - dbase != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_burst got=beats%0d/done%0d/busy%b exp=beats5/done1/busy0",
                     got_data.size() - base, done_cnt - dbase, busy);
        end
        for (int i = 0; i < 5 && base + i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[base+i] !== exp_q[i] || got_last[base+i] !== (i == 4)) begin
                n_errors++;
                $display("FAIL tmo_word%0d got=%h/%b exp=%h/%b", i, got_data[base+i],
                         got_last[base+i], exp_q[i], i == 4);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_burst();
`ifdef FIFO_RD_TIMEOUT_EN
        test_timeout();
`else
        test_below_threshold();
`endif
        test_ready_stall();
        test_empty_stall();
        test_reset_mid_burst();
        n_checks++;
        if (bad_req != 0 || unstable != 0) begin
            n_errors++;
            $display("FAIL global_protocol got=underflow%0d/unstable%0d exp=0/0", bad_req, unstable);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
